// File: rtl/mult_defs.sv
// Shared definitions for the sequential Booth multiplier: state encodings,
// default sizing and the Booth recoding helper.
package mult_defs;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mult_state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q-1}
  function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M into ACC,
// then arithmetic right shift of the whole {ACC, Q, q-1} register.
module booth_step
  import mult_defs::*;
#(
  parameter int unsigned AW = 33,
  parameter int unsigned QW = 32
) (
  input  logic [AW-1:0] acc_i,
  input  logic [QW-1:0] q_i,
  input  logic          qm1_i,
  input  logic [AW-1:0] m_i,
  output logic [AW-1:0] acc_o,
  output logic [QW-1:0] q_o,
  output logic          qm1_o
);

  logic [AW-1:0] sum;

  always_comb begin
    case (booth_decode(q_i[0], qm1_i))
      OP_ADD:  sum = acc_i + m_i;
      OP_SUB:  sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    acc_o = {sum[AW-1], sum[AW-1:1]};
    q_o   = {sum[0], q_i[QW-1:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier answering the control unit's multiply command.
// Define MULT_UNSIGNED_EN to add the is_unsigned port and unsigned products.
module booth_mult_unit
  import mult_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef MULT_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  // Unsigned mode runs a (WIDTH+1)-bit Booth, so Q gains the zero extension bit
`ifdef MULT_UNSIGNED_EN
  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned QW = WIDTH + 1;
`else
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned QW = WIDTH;
`endif

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [QW-1:0]    q_q, q_d;
  logic             qm1_q, qm1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULT_UNSIGNED_EN
  logic             uns_q, uns_d;
`endif

  logic [AW-1:0]    acc_nx;
  logic [QW-1:0]    q_nx;
  logic             qm1_nx;
  logic             a_ext_c;
  logic             b_ext_c;
  logic [CNT_W-1:0] last_c;

  booth_step #(
    .AW(AW),
    .QW(QW)
  ) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (acc_nx),
    .q_o   (q_nx),
    .qm1_o (qm1_nx)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_UNSIGNED_EN
    uns_d   = uns_q;
    a_ext_c = is_unsigned ? 1'b0 : A_in[WIDTH-1];
    b_ext_c = is_unsigned ? 1'b0 : B_in[WIDTH-1];
    last_c  = uns_q ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1);
`else
    a_ext_c = A_in[WIDTH-1];
    b_ext_c = B_in[WIDTH-1];
    last_c  = CNT_W'(WIDTH - 1);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {{(AW - WIDTH){a_ext_c}}, A_in};
`ifdef MULT_UNSIGNED_EN
          q_d     = {b_ext_c, B_in};
          uns_d   = is_unsigned;
`else
          q_d     = B_in;
`endif
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        acc_d  = acc_nx;
        q_d    = q_nx;
        qm1_d  = qm1_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == last_c) begin
`ifdef MULT_UNSIGNED_EN
          if (uns_q) begin
            hi_d = {acc_nx[WIDTH-2:0], q_nx[WIDTH]};
            lo_d = q_nx[WIDTH-1:0];
          end else begin
            hi_d = acc_nx[WIDTH-1:0];
            lo_d = q_nx[WIDTH:1];
          end
`else
          hi_d = acc_nx[WIDTH-1:0];
          lo_d = q_nx;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Hi_out = hi_q;
  assign Lo_out = lo_q;

endmodule
